// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU memory bridge: access-size encoding,
// bridge FSM states and the alignment predicate used by the optional
// alignment check (enabled with MIPS_MEM_BRIDGE_ALIGN_CHECK_EN).
package mips_cpu_pkg;

  // CPU data access size; the unused code 2'b11 is handled as a word
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  // Bridge FSM: wait for a request, drive the bus, wait for read data
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  // True when a half is not on a 2-byte or a word is not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_HALF) begin
      mis = addr_lo[0];
    end else if (size != SIZE_BYTE) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_bridge_if.sv
// CPU-side fetch/data handshakes plus the Avalon-MM master command and
// response signals. The d_err line exists only when
// MIPS_MEM_BRIDGE_ALIGN_CHECK_EN is defined.
interface mips_cpu_mem_bridge_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
  logic        d_err;
`endif

  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  // Bridge view: serves the CPU and masters the Avalon bus
  modport master (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    input  avm_waitrequest, avm_readdata,
    output i_ready, i_rdata, d_ready, d_rdata,
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    output d_err,
`endif
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

  // Environment view: CPU requester and Avalon slave memory
  modport slave (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    output avm_waitrequest, avm_readdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    input  d_err,
`endif
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

endinterface

// File: rtl/mips_cpu_mem_lane.sv
// Byte-lane steering between right-justified CPU data and the 32-bit
// Avalon data bus. Low address bits that do not fit the access size are
// ignored, so a misaligned half/word is treated as its aligned container.
module mips_cpu_mem_lane
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] lane_wdata,
  output logic [31:0] lane_rdata
);

  logic [1:0]  lo_al;
  logic [31:0] shifted;

  // Select enabled lanes, replicate store data and extract load data
  always_comb begin
    lo_al      = 2'b00;
    byteenable = 4'b1111;
    lane_wdata = wdata;
    shifted    = bus_rdata;
    lane_rdata = bus_rdata;
    case (size)
      SIZE_BYTE: begin
        lo_al      = addr_lo;
        byteenable = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        shifted    = bus_rdata >> {lo_al, 3'b000};
        lane_rdata = {24'h000000, shifted[7:0]};
      end
      SIZE_HALF: begin
        lo_al      = {addr_lo[1], 1'b0};
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        shifted    = bus_rdata >> {lo_al, 3'b000};
        lane_rdata = {16'h0000, shifted[15:0]};
      end
      default: begin
        lo_al      = 2'b00;
        byteenable = 4'b1111;
        lane_wdata = wdata;
        shifted    = bus_rdata >> {lo_al, 3'b000};
        lane_rdata = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_bridge.sv
// Arbitrates the MIPS instruction-fetch and data ports onto one Avalon-MM
// master with a single outstanding transfer; data wins over fetch.
// Optional feature: define MIPS_MEM_BRIDGE_ALIGN_CHECK_EN to reject
// misaligned half/word accesses with d_err instead of forcing alignment.
module mips_cpu_mem_bridge
  import mips_cpu_pkg::*;
#(
  parameter int READ_LATENCY = 1
)
(
  input logic                  clk,
  input logic                  reset_n,
  mips_cpu_mem_bridge_if.master mem_if
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_data_q, src_data_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lo_q, lo_d;
  logic [31:0]      address_q, address_d;
  logic [3:0]       be_q, be_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             i_ready_q, i_ready_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic             d_ready_q, d_ready_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
  logic             d_err_q, d_err_d;
`endif

  logic        d_go, i_go;
  logic [1:0]  sel_size, sel_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // A request is ignored while its own ready pulse is showing, because the
  // CPU only drops req on the edge that ends that pulse.
  assign d_go = mem_if.d_req && !d_ready_q;
  assign i_go = mem_if.i_req && !i_ready_q;

  // Lane logic sees the live request at grant time, the latched one later
  always_comb begin
    sel_size = size_q;
    sel_lo   = lo_q;
    if (state_q == IDLE) begin
      if (d_go) begin
        sel_size = mem_if.d_size;
        sel_lo   = mem_if.d_addr[1:0];
      end else begin
        sel_size = SIZE_WORD;
        sel_lo   = mem_if.i_addr[1:0];
      end
    end
  end

  mips_cpu_mem_lane u_lane (
    .size       (sel_size),
    .addr_lo    (sel_lo),
    .wdata      (mem_if.d_wdata),
    .bus_rdata  (mem_if.avm_readdata),
    .byteenable (lane_be),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata)
  );

  // Next state, next bus command and completion pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_data_d = src_data_q;
    size_d     = size_q;
    lo_d       = lo_q;
    address_d  = address_q;
    be_d       = be_q;
    read_d     = read_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    i_ready_d  = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_ready_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    d_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_go) begin
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
          if (is_misaligned(mem_if.d_size, mem_if.d_addr[1:0])) begin
            d_ready_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
`else
          begin
`endif
            state_d    = BUS;
            src_data_d = 1'b1;
            size_d     = sel_size;
            lo_d       = sel_lo;
            address_d  = {mem_if.d_addr[31:2], 2'b00};
            be_d       = lane_be;
            wdata_d    = lane_wdata;
            read_d     = !mem_if.d_we;
            write_d    = mem_if.d_we;
          end
        end else if (i_go) begin
          state_d    = BUS;
          src_data_d = 1'b0;
          size_d     = sel_size;
          lo_d       = sel_lo;
          address_d  = {mem_if.i_addr[31:2], 2'b00};
          be_d       = lane_be;
          read_d     = 1'b1;
          write_d    = 1'b0;
        end
      end
      BUS: begin
        if ((read_q || write_q) && !mem_if.avm_waitrequest) begin
          if (write_q) begin
            state_d   = IDLE;
            write_d   = 1'b0;
            d_ready_d = 1'b1;
          end else begin
            state_d = RESP;
            read_d  = 1'b0;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      RESP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (src_data_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = lane_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = lane_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything mid-transfer too
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_data_q <= 1'b0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      address_q  <= '0;
      be_q       <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      i_ready_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_ready_q  <= 1'b0;
      d_rdata_q  <= '0;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
      d_err_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_data_q <= src_data_d;
      size_q     <= size_d;
      lo_q       <= lo_d;
      address_q  <= address_d;
      be_q       <= be_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      i_ready_q  <= i_ready_d;
      i_rdata_q  <= i_rdata_d;
      d_ready_q  <= d_ready_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
      d_err_q    <= d_err_d;
`endif
    end
  end

  assign mem_if.avm_address    = address_q;
  assign mem_if.avm_byteenable = be_q;
  assign mem_if.avm_read       = read_q;
  assign mem_if.avm_write      = write_q;
  assign mem_if.avm_writedata  = wdata_q;
  assign mem_if.i_ready        = i_ready_q;
  assign mem_if.i_rdata        = i_rdata_q;
  assign mem_if.d_ready        = d_ready_q;
  assign mem_if.d_rdata        = d_rdata_q;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
  assign mem_if.d_err          = d_err_q;
`endif

endmodule

// File: tb/tb_mips_cpu_mem_bridge.sv
// Bench for mips_cpu_mem_bridge: randomized CPU traffic against a word
// memory slave with random waitrequest, checked against a reference model
// of the byte-lane rules. Also covers MIPS_MEM_BRIDGE_ALIGN_CHECK_EN builds.
module tb_mips_cpu_mem_bridge;
  import mips_cpu_pkg::*;

  localparam int LAT = 1;
  localparam logic [31:0] BASE = 32'hBFC00000;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
  } acc_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_cpu_mem_bridge_if bif();

  mips_cpu_mem_bridge #(.READ_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem_if  (bif)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] bus_mem [16];
  logic [31:0] ref_mem [16];
  acc_t acc_q[$];
  int wait_ctrl = 0;
  int rd_hi = 0;

  // ---------------- reference model (spec rules, plain arithmetic) ----------------
  function automatic logic [1:0] r_lo(input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (size == 2'd0) return 2'(a);
    if (size == 2'd1) return 2'((a / 2) * 2);
    return 2'd0;
  endfunction

  function automatic logic [3:0] r_be(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd0) return 4'(1 << lo);
    if (size == 2'd1) return 4'(3 << lo);
    return 4'hF;
  endfunction

  function automatic logic [31:0] r_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return 32'(w[7:0]) * 32'h01010101;
    if (size == 2'd1) return 32'(w[15:0]) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] r_load(input logic [1:0] size, input logic [1:0] lo, input logic [31:0] word);
    logic [31:0] v = word >> (int'(lo) * 8);
    if (size == 2'd0) return v & 32'h000000FF;
    if (size == 2'd1) return v & 32'h0000FFFF;
    return v;
  endfunction

  function automatic bit r_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // ---------------- Avalon slave memory, runs on the falling edge ----------------
  task automatic slave_loop();
    int          age = 0;
    int          rd_lat = 0;
    logic [31:0] rd_val = '0;
    bit          pend = 0;
    acc_t        prev = '0;
    acc_t        cur;
    bit          present, acc, wt;
    forever begin
      @(negedge clk);
      if (rd_lat > 0) begin
        rd_lat--;
        bif.avm_readdata = (rd_lat == 0) ? rd_val : $urandom();
      end else begin
        bif.avm_readdata = $urandom();
      end
      present = bif.avm_read || bif.avm_write;
      cur = '{addr: bif.avm_address, be: bif.avm_byteenable, wdata: bif.avm_writedata, wr: bif.avm_write};
      if (present) begin
        checks++;
        if (bif.avm_read && bif.avm_write) begin
          errors++;
          $display("FAIL rw_exclusive: avm_read=%b avm_write=%b, required not both", bif.avm_read, bif.avm_write);
        end
      end
      if (pend && reset_n) begin
        checks++;
        if (!present || cur.addr !== prev.addr || cur.be !== prev.be || cur.wr !== prev.wr
            || (cur.wr && cur.wdata !== prev.wdata)) begin
          errors++;
          $display("FAIL cmd_hold: got %h/%h/%h/%b present=%b, required held %h/%h/%h/%b",
                   cur.addr, cur.be, cur.wdata, cur.wr, present, prev.addr, prev.be, prev.wdata, prev.wr);
        end
      end
      wt = 1'b0;
      if (present) wt = (wait_ctrl < 0) ? ($urandom_range(0, 2) == 0) : (age < wait_ctrl);
      bif.avm_waitrequest = wt;
      acc = present && !wt;
      if (acc) begin
        acc_q.push_back(cur);
        if (cur.wr) begin
          for (int k = 0; k < 4; k++)
            if (cur.be[k]) bus_mem[cur.addr[5:2]][8*k +: 8] = cur.wdata[8*k +: 8];
        end else begin
          rd_val = bus_mem[cur.addr[5:2]];
          rd_lat = LAT;
        end
        age = 0;
      end else if (present) begin
        age++;
      end else begin
        age = 0;
      end
      if (bif.avm_read) rd_hi++;
      pend = present && !acc;
      prev = cur;
    end
  endtask

  // ---------------- transaction tasks ----------------
  task automatic do_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int          idx = int'(addr[5:2]);
    logic [1:0]  lo = r_lo(size, addr);
    logic [3:0]  ebe = r_be(size, lo);
    logic [31:0] ewd = r_wdata(size, wdata);
    logic [31:0] eload = r_load(size, lo, ref_mem[idx]);
    logic [31:0] held;
    bit          err_exp = 1'b0;
    bit          got = 1'b0;
    int          n = 0;
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    err_exp = r_misaligned(size, addr);
`endif
    acc_q.delete();
    bif.d_req = 1'b1; bif.d_we = we; bif.d_size = size; bif.d_addr = addr; bif.d_wdata = wdata;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bif.d_ready) begin got = 1'b1; break; end
    end
    bif.d_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL d_timeout: no d_ready for we=%b size=%0d addr=%h, required within 60 cycles", we, size, addr);
      return;
    end
    if (err_exp) begin
      checks++;
      if (acc_q.size() != 0 || n != 1) begin
        errors++;
        $display("FAIL align_err: bus cycles=%0d latency=%0d, required 0 and 1", acc_q.size(), n);
      end
    end else begin
      checks++;
      if (acc_q.size() != 1) begin
        errors++;
        $display("FAIL d_bus_count: got %0d transfers, required 1 (addr %h)", acc_q.size(), addr);
      end else begin
        checks++;
        if (acc_q[0].addr !== (addr & ~32'h3) || acc_q[0].be !== ebe || acc_q[0].wr !== we) begin
          errors++;
          $display("FAIL d_cmd: got addr %h be %b wr %b, required %h %b %b",
                   acc_q[0].addr, acc_q[0].be, acc_q[0].wr, addr & ~32'h3, ebe, we);
        end
        if (we) begin
          checks++;
          if (acc_q[0].wdata !== ewd) begin
            errors++;
            $display("FAIL d_wdata: got %h, required %h", acc_q[0].wdata, ewd);
          end
        end
      end
      if (!we) begin
        checks++;
        if (bif.d_rdata !== eload) begin
          errors++;
          $display("FAIL d_rdata: got %h, required %h (size %0d addr %h)", bif.d_rdata, eload, size, addr);
        end
      end else begin
        for (int k = 0; k < 4; k++)
          if (ebe[k]) ref_mem[idx][8*k +: 8] = ewd[8*k +: 8];
      end
    end
`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    checks++;
    if (bif.d_err !== err_exp) begin
      errors++;
      $display("FAIL d_err: got %b, required %b", bif.d_err, err_exp);
    end
`endif
    held = bif.d_rdata;
    @(negedge clk);
    checks++;
    if (bif.d_ready !== 1'b0 || bif.d_rdata !== held) begin
      errors++;
      $display("FAIL d_pulse: ready %b rdata %h, required 0 and held %h", bif.d_ready, bif.d_rdata, held);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    logic [31:0] exp = ref_mem[addr[5:2]];
    logic [31:0] held;
    bit got = 1'b0;
    acc_q.delete();
    rd_hi = 0;
    bif.i_req = 1'b1; bif.i_addr = addr;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bif.i_ready) begin got = 1'b1; break; end
    end
    bif.i_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL i_timeout: no i_ready for addr %h, required within 60 cycles", addr);
      return;
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].addr !== (addr & ~32'h3) || acc_q[0].be !== 4'hF || acc_q[0].wr !== 1'b0) begin
      errors++;
      $display("FAIL i_cmd: %0d transfers, required one read of %h with byteenable 1111", acc_q.size(), addr & ~32'h3);
    end
    checks++;
    if (bif.i_rdata !== exp) begin
      errors++;
      $display("FAIL i_rdata: got %h, required %h", bif.i_rdata, exp);
    end
    held = bif.i_rdata;
    @(negedge clk);
    checks++;
    if (bif.i_ready !== 1'b0 || bif.i_rdata !== held) begin
      errors++;
      $display("FAIL i_pulse: ready %b rdata %h, required 0 and held %h", bif.i_ready, bif.i_rdata, held);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit got = 1'b0;
    acc_q.delete();
    bif.i_req = 1'b1; bif.i_addr = BASE + 32'h8;
    #1 reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bif.avm_read !== 1'b0 || bif.avm_write !== 1'b0 || bif.i_ready !== 1'b0 || bif.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: rd %b wr %b iready %b dready %b, required all 0",
                 bif.avm_read, bif.avm_write, bif.i_ready, bif.d_ready);
      end
    end
    checks++;
    if (bif.avm_address !== 32'h0 || bif.avm_byteenable !== 4'h0 || bif.avm_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_cmd: addr %h be %b wdata %h, required zeros", bif.avm_address, bif.avm_byteenable, bif.avm_writedata);
    end
    checks++;
    if (bif.i_rdata !== 32'h0 || bif.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: i %h d %h, required zeros", bif.i_rdata, bif.d_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.avm_read !== 1'b1 || bif.avm_address !== BASE + 32'h8) begin
      errors++;
      $display("FAIL first_grant: rd %b addr %h, required 1 and %h", bif.avm_read, bif.avm_address, BASE + 32'h8);
    end
    for (int n = 0; n < 60; n++) begin
      if (bif.i_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    bif.i_req = 1'b0;
    checks++;
    if (!got || bif.i_rdata !== ref_mem[2]) begin
      errors++;
      $display("FAIL reset_fetch: ready seen %b rdata %h, required 1 and %h", got, bif.i_rdata, ref_mem[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_wait();
    wait_ctrl = 1;
    do_fetch(BASE);
    checks++;
    if (rd_hi != 2) begin
      errors++;
      $display("FAIL fetch_wait: avm_read high %0d cycles, required 2", rd_hi);
    end
    wait_ctrl = 0;
  endtask

  task automatic test_store_byte();
    wait_ctrl = 0;
    do_data(1'b1, 2'd0, BASE + 32'h13, 32'h000000AB);
    checks++;
    if (acc_q.size() != 1 || acc_q[0].be !== 4'b1000 || acc_q[0].wdata !== 32'hABABABAB) begin
      errors++;
      $display("FAIL store_byte: %0d transfers, required be 1000 wdata ABABABAB", acc_q.size());
    end
    do_data(1'b0, 2'd2, BASE + 32'h10, 32'h0);
    checks++;
    if (bif.d_rdata[31:24] !== 8'hAB) begin
      errors++;
      $display("FAIL store_readback: got %h in bits 31:24, required ab", bif.d_rdata[31:24]);
    end
  endtask

  task automatic test_half_load();
    bus_mem[0] = 32'h1234ABCD;
    ref_mem[0] = 32'h1234ABCD;
    do_data(1'b0, 2'd1, BASE + 32'h2, 32'h0);
    checks++;
    if (bif.d_rdata !== 32'h00001234) begin
      errors++;
      $display("FAIL half_load: got %h, required 00001234", bif.d_rdata);
    end
  endtask

  task automatic test_priority();
    logic [31:0] da = BASE + 32'h24;
    logic [31:0] fa = BASE + 32'h30;
    bit dd = 1'b0, fd = 1'b0;
    wait_ctrl = 0;
    acc_q.delete();
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_size = 2'd2; bif.d_addr = da;
    bif.i_req = 1'b1; bif.i_addr = fa;
    for (int n = 0; n < 80 && !(dd && fd); n++) begin
      @(negedge clk);
      if (bif.d_ready && !dd) begin
        dd = 1'b1;
        bif.d_req = 1'b0;
        checks++;
        if (acc_q.size() != 1 || acc_q[0].addr !== da || bif.d_rdata !== ref_mem[9]) begin
          errors++;
          $display("FAIL prio_data: %0d transfers rdata %h, required 1 transfer to %h and %h",
                   acc_q.size(), bif.d_rdata, da, ref_mem[9]);
        end
      end
      if (bif.i_ready && !fd) begin
        fd = 1'b1;
        bif.i_req = 1'b0;
        checks++;
        if (!dd || acc_q.size() != 2 || acc_q[1].addr !== fa || bif.i_rdata !== ref_mem[12]) begin
          errors++;
          $display("FAIL prio_fetch: data_done %b %0d transfers rdata %h, required 1, 2, %h",
                   dd, acc_q.size(), bif.i_rdata, ref_mem[12]);
        end
      end
    end
    bif.d_req = 1'b0; bif.i_req = 1'b0;
    checks++;
    if (!(dd && fd)) begin
      errors++;
      $display("FAIL prio_timeout: data %b fetch %b, required both complete", dd, fd);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    wait_ctrl = 0;
    do_data(1'b0, 2'd1, BASE + 32'h5, 32'h0);
    do_data(1'b0, 2'd2, BASE + 32'hA, 32'h0);
    do_data(1'b1, 2'd1, BASE + 32'h7, $urandom());
    do_data(1'b0, 2'd2, BASE + 32'h4, 32'h0);
    do_data(1'b0, 2'd2, BASE + 32'h2, 32'h0);
  endtask

  task automatic test_random();
    wait_ctrl = -1;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a = BASE + 32'($urandom_range(0, 63));
      int op = int'($urandom_range(0, 2));
      if (op == 0) do_fetch(a);
      else do_data(op == 2, 2'($urandom_range(0, 3)), a, $urandom());
    end
    wait_ctrl = 0;
  endtask

  task automatic test_back_to_back();
    wait_ctrl = 0;
    for (int t = 0; t < 6; t++) begin
      logic [31:0] a = BASE + 32'($urandom_range(0, 15) * 4);
      logic [31:0] w = $urandom();
      do_data(1'b1, 2'd2, a, w);
      do_data(1'b0, 2'd2, a, 32'h0);
      checks++;
      if (bif.d_rdata !== w) begin
        errors++;
        $display("FAIL b2b_readback: got %h, required %h", bif.d_rdata, w);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_ctrl = 1000;
    bif.i_req = 1'b1; bif.i_addr = BASE + 32'h4;
    repeat (2) @(negedge clk);
    checks++;
    if (bif.avm_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_bus: avm_read %b, required 1 while stalled", bif.avm_read);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bif.avm_read !== 1'b0 || bif.i_ready !== 1'b0 || bif.avm_address !== 32'h0 || bif.avm_byteenable !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: rd %b iready %b addr %h be %b, required all 0",
               bif.avm_read, bif.i_ready, bif.avm_address, bif.avm_byteenable);
    end
    bif.i_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bif.i_ready !== 1'b0 || bif.d_ready !== 1'b0 || bif.avm_read !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet: iready %b dready %b rd %b, required 0", bif.i_ready, bif.d_ready, bif.avm_read);
      end
    end
    reset_n = 1'b1;
    wait_ctrl = 0;
    do_fetch(BASE + 32'h4);
  endtask

  initial begin
    reset_n = 1'b1;
    bif.i_req = 1'b0; bif.i_addr = '0;
    bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_size = 2'd0; bif.d_addr = '0; bif.d_wdata = '0;
    bif.avm_waitrequest = 1'b0; bif.avm_readdata = '0;
    for (int k = 0; k < 16; k++) begin
      bus_mem[k] = $urandom();
      ref_mem[k] = bus_mem[k];
    end
    fork
      slave_loop();
    join_none
    test_reset();
    test_fetch_wait();
    test_store_byte();
    test_half_load();
    test_priority();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_cpu_mem_bridge.md
MIPS_CPU_MEM_BRIDGE -- requirements
Module: mips_cpu_mem_bridge

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: cycles from read acceptance to valid avm_readdata.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_req  in  1  instruction fetch request, held until i_ready.
REQ-005 SHALL have port i_addr  in  32  fetch byte address.
REQ-006 SHALL have port i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-007 SHALL have port i_rdata  out  32  fetched word.
REQ-008 SHALL have port d_req  in  1  data request, held with fields stable until d_ready.
REQ-009 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 SHALL have port d_addr  in  32  data byte address.
REQ-012 SHALL have port d_wdata  in  32  store data, right-justified.
REQ-013 SHALL have port d_ready  out  1  one-cycle pulse: data access complete.
REQ-014 SHALL have port d_rdata  out  32  load data, right-justified, zero-extended.
REQ-015 SHALL have ports avm_address out 32, avm_byteenable out 4, avm_read out 1, avm_write out 1, avm_writedata out 32: Avalon master command.
REQ-016 SHALL have ports avm_waitrequest in 1, avm_readdata in 32: Avalon slave response.

Function
REQ-017 FSM SHALL have states IDLE, BUS, RESP; IDLE->BUS on any req; BUS->RESP on read acceptance; BUS->IDLE on write acceptance; RESP->IDLE after READ_LATENCY cycles.
REQ-018 Acceptance SHALL be the posedge where (avm_read|avm_write) && !avm_waitrequest.
REQ-019 In IDLE with d_req and i_req both high, data SHALL win; fetch is served next IDLE cycle.
REQ-020 avm_* command outputs SHALL be registered, driven from the cycle after IDLE grant, and held constant until acceptance.
REQ-021 avm_address SHALL be {addr[31:2],2'b00}; fetch byteenable SHALL be 4'b1111.
REQ-022 Data byteenable: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?4'b1100:4'b0011; word -> 4'b1111.
REQ-023 avm_writedata SHALL place d_wdata low bytes in the enabled lanes (byte replicated x4, half replicated x2).
REQ-024 Load: d_rdata SHALL be avm_readdata enabled lanes shifted right by 8*addr[1:0], upper bits zero.
REQ-025 Store: d_ready SHALL pulse the cycle after write acceptance; load/fetch ready SHALL pulse the cycle after readdata is sampled, with rdata valid while ready=1 and held until the next completion.
REQ-026 avm_read and avm_write SHALL never be high together; at most one outstanding transfer.
REQ-027 Requests dropped before ready are protocol violations; behaviour undefined.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, all ready/avm_read/avm_write/error outputs 0, avm_address/byteenable/writedata/rdata 0, including mid-transfer.
REQ-029 After reset release, the first grant SHALL not occur before the first posedge with reset_n high.

Configuration
REQ-030 With MIPS_MEM_BRIDGE_ALIGN_CHECK_EN defined: extra output d_err out 1; misaligned half (addr[0]=1) or word (addr[1:0]!=0) SHALL issue no bus cycle, pulse d_ready and d_err together one cycle after grant.
REQ-031 Without the macro: no d_err port; misaligned addresses SHALL have low bits ignored (forced alignment) and proceed normally.

Structure
REQ-032 Shared package mips_cpu_pkg SHALL hold the size enum (SIZE_BYTE/HALF/WORD) and FSM state typedef.
REQ-033 One sub-module mips_cpu_mem_lane (combinational byteenable, write-lane and read-extract logic) SHALL be instantiated.

Verification
REQ-034 Fetch 0xBFC00000, waitrequest 1 for 1 cycle -> avm_read held 2 cycles, i_ready pulses with i_rdata = memory word.
REQ-035 Simultaneous d_req load and i_req -> data transfer first, fetch issued after d_ready.
REQ-036 Store byte 0xAB to 0xBFC00013 -> byteenable 4'b1000, writedata 0xABABABAB; subsequent word load returns 0xAB in bits 31:24.
REQ-037 Half load at 0xBFC00002 of word 0x1234ABCD -> d_rdata 0x00001234.
REQ-038 reset_n low during BUS with waitrequest high -> avm_read 0 immediately, no ready pulse, clean transfer after release.
REQ-039 Macro defined, word load at 0xBFC00002 -> no avm_read, d_ready=d_err=1 for one cycle.
